turn_scheduler: RTL and testbench

Sequences the Generals game between players. It tracks the current and next player, the round counter and a per-turn countdown. It also requests the per-round troop-growth pass from the game-logic datapath and detects game over. It sits beside the game logic on `clk_100M`: it consumes move-completion and alive-player status, and drives who may act and when growth runs.

---
 rtl/turn_scheduler_pkg.sv | 20 ++
 rtl/turn_scheduler_player_rotator.sv | 49 ++++
 rtl/turn_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_turn_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/turn_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// turn_scheduler_pkg
// Types shared between the turn scheduler and the game-logic datapath.
//   turn_state_t : scheduler state (IDLE / TURN / GROW / OVER)
//   player_id_t  : player identifier, 1..7 for players, 0 for neutral/none
// -----------------------------------------------------------------------------
package turn_scheduler_pkg;

    localparam int PLAYER_ID_W = 3;

    typedef logic [PLAYER_ID_W-1:0] player_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        GROW = 2'd2,
        OVER = 2'd3
    } turn_state_t;

endpackage : turn_scheduler_pkg

// File: rtl/turn_scheduler_player_rotator.sv
// -----------------------------------------------------------------------------
// player_rotator
// Purely combinational helper for the turn scheduler.
// Ports:
//   alive_mask : bit i set means player i+1 is alive
//   start_id   : scan origin; 0 scans from player 1 upward
//   next_id    : first alive ID above start_id, wrapping around; may equal
//                start_id when it is the sole survivor; 0 when nobody is alive
//   alive_cnt  : number of alive players
// -----------------------------------------------------------------------------
module player_rotator
    import turn_scheduler_pkg::*;
#(
    parameter int MAX_PLAYER_CNT = 7,
    parameter int ID_W           = PLAYER_ID_W,
    parameter int CNT_W          = 3
) (
    input  logic [MAX_PLAYER_CNT-1:0] alive_mask,
    input  logic [ID_W-1:0]           start_id,
    output logic [ID_W-1:0]           next_id,
    output logic [CNT_W-1:0]          alive_cnt
);

    logic found_s;
    logic hit_s;

    // Population count plus a two-pass cyclic priority scan: first the IDs
    // strictly above start_id, then the IDs from 1 up to start_id inclusive.
    always_comb begin
        next_id   = '0;
        alive_cnt = '0;
        found_s   = 1'b0;
        hit_s     = 1'b0;
        for (int j = 0; j < MAX_PLAYER_CNT; j++) begin
            alive_cnt = alive_cnt + CNT_W'(alive_mask[j]);
        end
        for (int j = 0; j < MAX_PLAYER_CNT; j++) begin
            hit_s   = alive_mask[j] & ~found_s & ((ID_W+1)'(j + 1) > {1'b0, start_id});
            next_id = hit_s ? ID_W'(j + 1) : next_id;
            found_s = found_s | hit_s;
        end
        for (int j = 0; j < MAX_PLAYER_CNT; j++) begin
            hit_s   = alive_mask[j] & ~found_s & ((ID_W+1)'(j + 1) <= {1'b0, start_id});
            next_id = hit_s ? ID_W'(j + 1) : next_id;
            found_s = found_s | hit_s;
        end
    end

endmodule : player_rotator

// File: rtl/turn_scheduler.sv
// -----------------------------------------------------------------------------
// turn_scheduler
// Sequences turns of the Generals game: current/next player, round counter,
// per-turn countdown, growth-pass handshake with the datapath, game over.
// Ports:
//   clk_100M, reset      : clock, asynchronous active-high reset
//   start                : pulse, starts/restarts a game (IDLE or OVER only)
//   alive_mask           : bit i set means player i+1 is alive
//   move_done            : pulse, current player committed a move
//   grow_ack             : pulse, datapath finished the growth pass
//   current_player       : player allowed to act, 0 when no turn is active
//   next_player          : next alive player after current_player (comb.)
//   round                : round number, starts at 1, saturates
//   turn_active          : high in TURN
//   seconds_left         : remaining seconds of the turn, 0 outside TURN
//   grow_req / grow_all  : growth request level and all-land qualifier
//   game_over / winner   : game ended, sole survivor or 0
// -----------------------------------------------------------------------------
module turn_scheduler
    import turn_scheduler_pkg::*;
#(
    parameter int MAX_PLAYER_CNT      = 7,
    parameter int LOG2_MAX_PLAYER_CNT = 3,
    parameter int LOG2_MAX_ROUND      = 12,
    parameter int TICKS_PER_SEC       = 100_000_000,
    parameter int TURN_SECONDS        = 10,
    parameter int LAND_GROW_PERIOD    = 25
) (
    input  logic                               clk_100M,
    input  logic                               reset,
    input  logic                               start,
    input  logic [MAX_PLAYER_CNT-1:0]          alive_mask,
    input  logic                               move_done,
    input  logic                               grow_ack,
    output logic [LOG2_MAX_PLAYER_CNT-1:0]     current_player,
    output logic [LOG2_MAX_PLAYER_CNT-1:0]     next_player,
    output logic [LOG2_MAX_ROUND-1:0]          round,
    output logic                               turn_active,
    output logic [$clog2(TURN_SECONDS+1)-1:0]  seconds_left,
    output logic                               grow_req,
    output logic                               grow_all,
    output logic                               game_over,
    output logic [LOG2_MAX_PLAYER_CNT-1:0]     winner
);

    localparam int ID_W   = LOG2_MAX_PLAYER_CNT;
    localparam int SEC_W  = $clog2(TURN_SECONDS + 1);
    localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int CNT_W  = $clog2(MAX_PLAYER_CNT + 1);
    localparam int RND_W  = LOG2_MAX_ROUND;

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0]  SEC_RELOAD  = SEC_W'(TURN_SECONDS);
    localparam logic [RND_W-1:0]  ROUND_MAX   = {RND_W{1'b1}};
    localparam logic [RND_W-1:0]  GROW_PERIOD = RND_W'(LAND_GROW_PERIOD);

    turn_state_t       state_r;
    logic [ID_W-1:0]   current_player_r;
    logic [RND_W-1:0]  round_r;
    logic              turn_active_r;
    logic [SEC_W-1:0]  seconds_left_r;
    logic [TICK_W-1:0] tick_r;
    logic              grow_req_r;
    logic              grow_all_r;
    logic              game_over_r;
    logic [ID_W-1:0]   winner_r;

    logic [ID_W-1:0]   next_player_s;
    logic [CNT_W-1:0]  alive_cnt_s;
    logic              cur_alive_s;
    logic              few_alive_s;
    logic              timeout_s;
    logic              turn_end_s;
    logic              wrap_s;
    logic              grow_all_s;
    logic [RND_W-1:0]  round_inc_s;

    // current_player is 0 outside TURN, so the same scan yields the lowest
    // alive ID whenever a new round or game begins.
    player_rotator #(
        .MAX_PLAYER_CNT (MAX_PLAYER_CNT),
        .ID_W           (ID_W),
        .CNT_W          (CNT_W)
    ) u_player_rotator (
        .alive_mask (alive_mask),
        .start_id   (current_player_r),
        .next_id    (next_player_s),
        .alive_cnt  (alive_cnt_s)
    );

    // Alive bit of the player currently holding the turn.
    always_comb begin
        cur_alive_s = 1'b0;
        for (int j = 0; j < MAX_PLAYER_CNT; j++) begin
            cur_alive_s = cur_alive_s | (alive_mask[j] & (current_player_r == ID_W'(j + 1)));
        end
    end

    assign few_alive_s = (alive_cnt_s <= CNT_W'(1));
    // The countdown reaching 0 is itself the registered timeout event.
    assign timeout_s   = (seconds_left_r == SEC_W'(0));
    assign turn_end_s  = move_done | timeout_s | ~cur_alive_s;
    assign wrap_s      = (next_player_s <= current_player_r);
    assign grow_all_s  = ((round_r % GROW_PERIOD) == RND_W'(0));
    assign round_inc_s = (round_r == ROUND_MAX) ? round_r : (round_r + RND_W'(1));

    // Scheduler FSM with tick, seconds and round counters and registered outputs.
    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            state_r          <= IDLE;
            current_player_r <= '0;
            round_r          <= '0;
            turn_active_r    <= 1'b0;
            seconds_left_r   <= '0;
            tick_r           <= '0;
            grow_req_r       <= 1'b0;
            grow_all_r       <= 1'b0;
            game_over_r      <= 1'b0;
            winner_r         <= '0;
        end else begin
            case (state_r)
                IDLE, OVER: begin
                    if (start) begin
                        if (few_alive_s) begin
                            state_r          <= OVER;
                            current_player_r <= '0;
                            game_over_r      <= 1'b1;
                            winner_r         <= next_player_s;
                        end else begin
                            state_r          <= TURN;
                            current_player_r <= next_player_s;
                            round_r          <= RND_W'(1);
                            turn_active_r    <= 1'b1;
                            seconds_left_r   <= SEC_RELOAD;
                            tick_r           <= '0;
                            game_over_r      <= 1'b0;
                            winner_r         <= '0;
                        end
                    end
                end
                TURN: begin
                    if (turn_end_s) begin
                        tick_r <= '0;
                        if (few_alive_s) begin
                            state_r          <= OVER;
                            current_player_r <= '0;
                            turn_active_r    <= 1'b0;
                            seconds_left_r   <= '0;
                            game_over_r      <= 1'b1;
                            // With at most one survivor the scan returns it, or 0.
                            winner_r         <= next_player_s;
                        end else if (wrap_s) begin
                            state_r          <= GROW;
                            current_player_r <= '0;
                            turn_active_r    <= 1'b0;
                            seconds_left_r   <= '0;
                            grow_req_r       <= 1'b1;
                            grow_all_r       <= grow_all_s;
                        end else begin
                            current_player_r <= next_player_s;
                            seconds_left_r   <= SEC_RELOAD;
                        end
                    end else if (tick_r == TICK_LAST) begin
                        tick_r         <= '0;
                        seconds_left_r <= seconds_left_r - SEC_W'(1);
                    end else begin
                        tick_r <= tick_r + TICK_W'(1);
                    end
                end
                GROW: begin
                    // An ack is only honoured once the request is visible.
                    if (grow_ack && grow_req_r) begin
                        round_r    <= round_inc_s;
                        grow_req_r <= 1'b0;
                        grow_all_r <= 1'b0;
                        if (alive_cnt_s == CNT_W'(0)) begin
                            state_r     <= OVER;
                            game_over_r <= 1'b1;
                            winner_r    <= '0;
                        end else begin
                            state_r          <= TURN;
                            current_player_r <= next_player_s;
                            turn_active_r    <= 1'b1;
                            seconds_left_r   <= SEC_RELOAD;
                            tick_r           <= '0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign current_player = current_player_r;
    assign next_player    = next_player_s;
    assign round          = round_r;
    assign turn_active    = turn_active_r;
    assign seconds_left   = seconds_left_r;
    assign grow_req       = grow_req_r;
    assign grow_all       = grow_all_r;
    assign game_over      = game_over_r;
    assign winner         = winner_r;

endmodule : turn_scheduler

// File: tb/tb_turn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_turn_scheduler
// Directed bench for turn_scheduler with TICKS_PER_SEC=4, TURN_SECONDS=3,
// LAND_GROW_PERIOD=2. Inputs change 1 ns after a rising edge and outputs are
// sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_turn_scheduler;

    logic        clk_100M = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  alive_mask;
    logic        move_done;
    logic        grow_ack;
    logic [2:0]  current_player;
    logic [2:0]  next_player;
    logic [11:0] round;
    logic        turn_active;
    logic [1:0]  seconds_left;
    logic        grow_req;
    logic        grow_all;
    logic        game_over;
    logic [2:0]  winner;

    int tests_run    = 0;
    int tests_failed = 0;

    turn_scheduler #(
        .MAX_PLAYER_CNT      (7),
        .LOG2_MAX_PLAYER_CNT (3),
        .LOG2_MAX_ROUND      (12),
        .TICKS_PER_SEC       (4),
        .TURN_SECONDS        (3),
        .LAND_GROW_PERIOD    (2)
    ) dut (
        .clk_100M       (clk_100M),
        .reset          (reset),
        .start          (start),
        .alive_mask     (alive_mask),
        .move_done      (move_done),
        .grow_ack       (grow_ack),
        .current_player (current_player),
        .next_player    (next_player),
        .round          (round),
        .turn_active    (turn_active),
        .seconds_left   (seconds_left),
        .grow_req       (grow_req),
        .grow_all       (grow_all),
        .game_over      (game_over),
        .winner         (winner)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; alive_mask = 7'b0000000;
        move_done = 1'b0; grow_ack = 1'b0;
        #3;
        check("rst_cur",    16'(current_player), 16'd0);
        check("rst_round",  16'(round),          16'd0);
        check("rst_secs",   16'(seconds_left),   16'd0);
        check("rst_active", 16'(turn_active),    16'd0);
        check("rst_greq",   16'(grow_req),       16'd0);
        check("rst_gall",   16'(grow_all),       16'd0);
        check("rst_over",   16'(game_over),      16'd0);
        check("rst_winner", 16'(winner),         16'd0);
        step(2);
        reset = 1'b0;
        step(1);

        // start and basic rotation
        alive_mask = 7'b0000111; start = 1'b1; step(1); start = 1'b0;
        check("start_cur",    16'(current_player), 16'd1);
        check("start_round",  16'(round),          16'd1);
        check("start_secs",   16'(seconds_left),   16'd3);
        check("start_active", 16'(turn_active),    16'd1);
        check("start_next",   16'(next_player),    16'd2);
        move_done = 1'b1; step(1); move_done = 1'b0;
        check("rot_cur2", 16'(current_player), 16'd2);
        move_done = 1'b1; step(1); move_done = 1'b0;
        check("rot_cur3",  16'(current_player), 16'd3);
        check("rot_next1", 16'(next_player),    16'd1);

        // round wrap into growth, round 1 -> cities/crowns only
        move_done = 1'b1; step(1); move_done = 1'b0;
        check("grow_req",    16'(grow_req),       16'd1);
        check("grow_all_r1", 16'(grow_all),       16'd0);
        check("grow_cur",    16'(current_player), 16'd0);
        check("grow_active", 16'(turn_active),    16'd0);
        check("grow_secs",   16'(seconds_left),   16'd0);
        grow_ack = 1'b1; step(1); grow_ack = 1'b0;
        check("ack_round", 16'(round),          16'd2);
        check("ack_cur",   16'(current_player), 16'd1);
        check("ack_greq",  16'(grow_req),       16'd0);
        check("ack_secs",  16'(seconds_left),   16'd3);

        // timeout: 4 ticks per second, 3 seconds, then a 0 cycle
        step(4);
        check("to_secs2", 16'(seconds_left), 16'd2);
        step(4);
        check("to_secs1", 16'(seconds_left), 16'd1);
        step(4);
        check("to_secs0",    16'(seconds_left),   16'd0);
        check("to_cur_hold", 16'(current_player), 16'd1);
        step(1);
        check("to_cur",    16'(current_player), 16'd2);
        check("to_reload", 16'(seconds_left),   16'd3);

        // move_done in the timeout cycle gives a single advance
        step(12);
        check("sim_secs0", 16'(seconds_left), 16'd0);
        move_done = 1'b1; step(1); move_done = 1'b0;
        check("sim_cur",  16'(current_player), 16'd3);
        check("sim_secs", 16'(seconds_left),   16'd3);
        step(1);
        check("sim_hold", 16'(current_player), 16'd3);

        // wrap in round 2 -> all land grows; ack coinciding with turn end ignored
        move_done = 1'b1; grow_ack = 1'b1; step(1); move_done = 1'b0; grow_ack = 1'b0;
        check("grow_all_r2", 16'(grow_all), 16'd1);
        check("grow_req_r2", 16'(grow_req), 16'd1);
        step(1);
        check("early_ack_greq",  16'(grow_req), 16'd1);
        check("early_ack_round", 16'(round),    16'd2);

        // asynchronous reset while in GROW
        reset = 1'b1;
        #2;
        check("arst_greq",   16'(grow_req), 16'd0);
        check("arst_gall",   16'(grow_all), 16'd0);
        check("arst_round",  16'(round),    16'd0);
        step(1);
        reset = 1'b0; grow_ack = 1'b1; step(1); grow_ack = 1'b0;
        check("post_rst_round",  16'(round),          16'd0);
        check("post_rst_cur",    16'(current_player), 16'd0);
        check("post_rst_active", 16'(turn_active),    16'd0);

        // death and skipping
        alive_mask = 7'b0001111; start = 1'b1; step(1); start = 1'b0;
        check("d_cur1", 16'(current_player), 16'd1);
        alive_mask = 7'b0001101;
        #1;
        check("d_next3", 16'(next_player), 16'd3);
        alive_mask = 7'b0001100; step(1);
        check("d_cur3",  16'(current_player), 16'd3);
        check("d_next4", 16'(next_player),    16'd4);

        // game over with player 3 the sole survivor
        alive_mask = 7'b0000100; step(1);
        check("ov_hold", 16'(current_player), 16'd3);
        move_done = 1'b1; step(1); move_done = 1'b0;
        check("ov_flag",   16'(game_over),      16'd1);
        check("ov_winner", 16'(winner),         16'd3);
        check("ov_active", 16'(turn_active),    16'd0);
        check("ov_cur",    16'(current_player), 16'd0);

        // start with nobody alive -> OVER with no winner
        alive_mask = 7'b0000000; start = 1'b1; step(1); start = 1'b0;
        check("none_flag",   16'(game_over), 16'd1);
        check("none_winner", 16'(winner),    16'd0);

        // restart from OVER
        alive_mask = 7'b0000011; start = 1'b1; step(1); start = 1'b0;
        check("re_cur",   16'(current_player), 16'd1);
        check("re_next",  16'(next_player),    16'd2);
        check("re_over",  16'(game_over),      16'd0);
        check("re_round", 16'(round),          16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_turn_scheduler
